// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared function codes and divide-wait state encoding
package alu_pkg;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } div_state_e;

endpackage

// File: rtl/alu_result_select_if.sv
// rtl/alu_result_select_if.sv - operation/result handshake bundle for the result selector
interface alu_result_select_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] signal;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shifter_out;
  logic [WIDTH-1:0]   hi_in;
  logic [WIDTH-1:0]   lo_in;
  logic [WIDTH-1:0]   data_out;
  logic               out_valid;
  logic               out_ready;
  logic               err;
  logic               div_busy;

  modport master (
    output in_valid, signal, alu_out, shifter_out, hi_in, lo_in, out_ready,
    input  in_ready, data_out, out_valid, err, div_busy
  );

  modport slave (
    input  in_valid, signal, alu_out, shifter_out, hi_in, lo_in, out_ready,
    output in_ready, data_out, out_valid, err, div_busy
  );
endinterface

// File: rtl/div_wait_timer.sv
// rtl/div_wait_timer.sv - tracks the DIVU latency window after each accepted divide
module div_wait_timer
  import alu_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_busy,
  output logic o_last
);
  localparam int CNT_W    = (DIV_LAT < 1) ? 1 : $clog2(DIV_LAT + 1);
  localparam bit HAS_WAIT = (DIV_LAT > 0);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A new DIVU can only arrive in the final wait cycle, so restart from there.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start && HAS_WAIT) begin
          w_state_nxt = DIV_WAIT;
          w_cnt_nxt   = CNT_W'(DIV_LAT);
        end
      end
      DIV_WAIT: begin
        if (i_start) begin
          w_cnt_nxt = CNT_W'(DIV_LAT);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == DIV_WAIT);
  assign o_last = (r_state == DIV_WAIT) && (r_cnt == CNT_W'(1));
endmodule

// File: rtl/alu_result_select.sv
// rtl/alu_result_select.sv - registered write-back source select with DIVU Hi/Lo interlock
module alu_result_select
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6,
  parameter int DIV_LAT = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_select_if.slave  bus
);
  logic             w_is_divu;
  logic             w_is_hilo;
  logic             w_busy;
  logic             w_last;
  logic             w_hold;
  logic             w_blocked;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err;

  assign w_is_divu = (bus.signal == FUNCT_W'(FN_DIVU));
  assign w_is_hilo = w_is_divu ||
                     (bus.signal == FUNCT_W'(FN_MFHI)) ||
                     (bus.signal == FUNCT_W'(FN_MFLO));

  always_comb begin
    w_sel_data = '0;
    w_sel_err  = 1'b0;
    case (bus.signal)
      FUNCT_W'(FN_AND), FUNCT_W'(FN_OR), FUNCT_W'(FN_ADD),
      FUNCT_W'(FN_SUB), FUNCT_W'(FN_SLT): w_sel_data = bus.alu_out;
      FUNCT_W'(FN_SLL):                   w_sel_data = bus.shifter_out;
      FUNCT_W'(FN_MFHI):                  w_sel_data = bus.hi_in;
      FUNCT_W'(FN_MFLO):                  w_sel_data = bus.lo_in;
      FUNCT_W'(FN_DIVU):                  w_sel_data = '0;
      default:                            w_sel_err  = 1'b1;
    endcase
  end

  div_wait_timer #(
    .DIV_LAT (DIV_LAT)
  ) u_div_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept && w_is_divu),
    .o_busy  (w_busy),
    .o_last  (w_last)
  );

  // Hi/Lo are usable in the last wait cycle, so the interlock releases one cycle before div_busy.
  assign w_hold     = w_busy && !w_last;
  assign w_blocked  = w_hold && w_is_hilo;
  assign w_in_ready = (!r_valid || bus.out_ready) && !w_blocked;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept && !w_is_divu) begin
      r_data  <= w_sel_data;
      r_err   <= w_sel_err;
      r_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.data_out  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.err       = r_err;
  assign bus.div_busy  = w_busy;
endmodule

// File: tb/tb_alu_result_select.sv
// tb/tb_alu_result_select.sv - vector table, directed corner sequences and random run against a cycle model
module tb_alu_result_select;
  localparam int W  = 32;
  localparam int FW = 6;
  localparam int DL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_result_select_if #(.WIDTH(W), .FUNCT_W(FW)) bus ();

  alu_result_select #(.WIDTH(W), .FUNCT_W(FW), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: held result plus absolute cycle numbers for the divide window.
  int          cyc;
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_err;
  int          m_free;
  int          m_busy_end;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, s, h, l;
    logic [31:0] exp_d;
    bit          exp_e;
  } vec_t;

  vec_t tbl[9];

  logic [5:0] codes[11] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a, 6'h00,
                             6'h10, 6'h12, 6'h1b, 6'h3f, 6'h01};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_sel(input logic [5:0] f, output bit e);
    e = 1'b0;
    if (f == 6'h24 || f == 6'h25 || f == 6'h20 || f == 6'h22 || f == 6'h2a) return bus.alu_out;
    if (f == 6'h00) return bus.shifter_out;
    if (f == 6'h10) return bus.hi_in;
    if (f == 6'h12) return bus.lo_in;
    if (f == 6'h1b) return 32'h0;
    e = 1'b1;
    return 32'h0;
  endfunction

  function automatic bit touches_hilo(input logic [5:0] f);
    return (f == 6'h10) || (f == 6'h12) || (f == 6'h1b);
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step();
    bit          exp_ir;
    bit          e;
    logic [31:0] d;
    @(negedge clk);
    exp_ir = (!m_valid || bus.out_ready) && !(cyc < m_free && touches_hilo(bus.signal));
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ir});
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    check("div_busy", {31'b0, bus.div_busy}, {31'b0, (cyc <= m_busy_end)});
    if (m_valid) begin
      check("data_out", bus.data_out, m_data);
      check("err", {31'b0, bus.err}, {31'b0, m_err});
    end
    if (reset) begin
      m_valid = 0; m_data = 0; m_err = 0; m_free = 0; m_busy_end = -1;
    end else if (bus.in_valid && exp_ir && bus.signal != 6'h1b) begin
      d = ref_sel(bus.signal, e);
      m_valid = 1; m_data = d; m_err = e;
    end else begin
      if (bus.in_valid && exp_ir && DL > 0) begin
        m_free = cyc + DL; m_busy_end = cyc + DL;
      end
      if (bus.out_ready) m_valid = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] f, input bit ordy);
    bus.in_valid  = v;
    bus.signal    = f;
    bus.out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 6'h00, 1);
    bus.alu_out = 0; bus.shifter_out = 0; bus.hi_in = 0; bus.lo_in = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0; m_valid = 0; m_data = 0; m_err = 0; m_free = 0; m_busy_end = -1;
    check("rst data_out", bus.data_out, 32'h0);
    check("rst out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst err", {31'b0, bus.err}, 32'h0);
    check("rst div_busy", {31'b0, bus.div_busy}, 32'h0);
    reset = 1'b0;

    // Single-op vectors from idle with the sink always ready
    tbl[0] = '{6'h24, 32'h0000_00ff, 32'h1, 32'h2, 32'h3, 32'h0000_00ff, 0};
    tbl[1] = '{6'h25, 32'h1234_5678, 32'h1, 32'h2, 32'h3, 32'h1234_5678, 0};
    tbl[2] = '{6'h20, 32'hdead_beef, 32'h1, 32'h2, 32'h3, 32'hdead_beef, 0};
    tbl[3] = '{6'h22, 32'hffff_ffff, 32'h1, 32'h2, 32'h3, 32'hffff_ffff, 0};
    tbl[4] = '{6'h2a, 32'h0000_0001, 32'h9, 32'h2, 32'h3, 32'h0000_0001, 0};
    tbl[5] = '{6'h00, 32'h5, 32'h8000_0000, 32'h2, 32'h3, 32'h8000_0000, 0};
    tbl[6] = '{6'h10, 32'h5, 32'h6, 32'hcafe_0001, 32'h3, 32'hcafe_0001, 0};
    tbl[7] = '{6'h12, 32'h5, 32'h6, 32'h7, 32'h0bad_f00d, 32'h0bad_f00d, 0};
    tbl[8] = '{6'h3f, 32'h5, 32'h6, 32'h7, 32'h8, 32'h0, 1};
    for (int i = 0; i < 9; i++) begin
      bus.alu_out = tbl[i].a; bus.shifter_out = tbl[i].s;
      bus.hi_in = tbl[i].h; bus.lo_in = tbl[i].l;
      drive(1, tbl[i].f, 1);
      step();
      drive(0, 6'h20, 1);
      check($sformatf("vec%0d data", i), bus.data_out, tbl[i].exp_d);
      check($sformatf("vec%0d err", i), {31'b0, bus.err}, {31'b0, tbl[i].exp_e});
      check($sformatf("vec%0d valid", i), {31'b0, bus.out_valid}, 32'h1);
      step();
    end

    // ADD then idle: result visible one cycle, then drained
    bus.alu_out = 32'h5; drive(1, 6'h20, 1); step();
    drive(0, 6'h20, 1);
    check("add data", bus.data_out, 32'h5);
    step();
    check("add drained", {31'b0, bus.out_valid}, 32'h0);

    // Back-to-back SLL then OR
    bus.shifter_out = 32'h80; drive(1, 6'h00, 1); step();
    check("sll data", bus.data_out, 32'h80);
    bus.alu_out = 32'hf0; drive(1, 6'h25, 1);
    check("b2b in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check("or data", bus.data_out, 32'hf0);
    drive(0, 6'h20, 1); step();

    // DIVU then MFHI waits out the latency window
    drive(1, 6'h1b, 1); step();
    bus.hi_in = 32'h1234; drive(1, 6'h10, 1);
    for (int k = 1; k < DL; k++) begin
      check($sformatf("mfhi stall t+%0d", k), {31'b0, bus.in_ready}, 32'h0);
      step();
    end
    check("mfhi released", {31'b0, bus.in_ready}, 32'h1);
    check("busy last cycle", {31'b0, bus.div_busy}, 32'h1);
    step();
    drive(0, 6'h20, 1);
    check("mfhi data", bus.data_out, 32'h1234);
    check("busy cleared", {31'b0, bus.div_busy}, 32'h0);
    step();

    // ALU op proceeds during the wait
    drive(1, 6'h1b, 1); step();
    bus.alu_out = 32'hffff_ffff; drive(1, 6'h22, 1); step();
    drive(0, 6'h20, 1);
    check("sub in wait", bus.data_out, 32'hffff_ffff);
    check("sub busy", {31'b0, bus.div_busy}, 32'h1);
    repeat (DL + 1) step();

    // Backpressure hold, then consume-and-replace with MFLO
    bus.alu_out = 32'h77; drive(1, 6'h2a, 1); step();
    bus.alu_out = 32'h99; drive(1, 6'h20, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold data", bus.data_out, 32'h77);
    end
    bus.lo_in = 32'ha; drive(1, 6'h12, 1); step();
    drive(0, 6'h20, 1);
    check("mflo replace", bus.data_out, 32'ha);
    check("mflo valid", {31'b0, bus.out_valid}, 32'h1);
    step();

    // Reset during the wait with two cycles left
    drive(1, 6'h1b, 1); step();
    drive(0, 6'h20, 1); step(); step();
    reset = 1'b1; step();
    reset = 1'b0;
    check("rst busy", {31'b0, bus.div_busy}, 32'h0);
    check("rst valid", {31'b0, bus.out_valid}, 32'h0);
    bus.hi_in = 32'h4321; drive(1, 6'h10, 1);
    check("rst mfhi ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check("rst mfhi data", bus.data_out, 32'h4321);
    drive(0, 6'h20, 1); step();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      bus.alu_out     = $urandom;
      bus.shifter_out = $urandom;
      bus.hi_in       = $urandom;
      bus.lo_in       = $urandom;
      drive($urandom_range(0, 3) != 0, codes[$urandom_range(0, 10)], $urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
